// File: rtl/pkt_rx_framer.sv
// pkt_rx_framer: pops a header byte plus up to 7 payload bytes from a show-ahead FIFO and holds them as one packet.
// Define PKT_RX_TIMEOUT_EN to abort a packet after TIMEOUT_CYCLES idle cycles mid-payload.
module pkt_rx_framer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        rclk,
    input  logic        rrst_n,
    input  logic [7:0]  rdata,
    input  logic        rempty,
    output logic        rinc,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [4:0]  pkt_op,
    output logic [2:0]  pkt_len,
    output logic [55:0] pkt_data,
    output logic [15:0] pkt_count,
    output logic        rx_timeout
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;

    state_t      state, state_nx;
    logic [2:0]  idx;
    logic [15:0] cnt;
    logic        pop, abort;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_range
        $error("pkt_rx_framer: TIMEOUT_CYCLES must be 2..65535");
    end

    // Gated by reset so the FIFO is never popped while the framer is held in reset.
    assign pop       = rrst_n && !rempty && (state == IDLE || state == PAYLOAD);
    assign rinc      = pop;
    assign pkt_valid = state == HOLD;
    assign pkt_count = cnt;

`ifdef PKT_RX_TIMEOUT_EN
    logic [15:0] idle;
    logic        to_q;

    assign abort      = state == PAYLOAD && rempty && idle == 16'(TIMEOUT_CYCLES - 1);
    assign rx_timeout = to_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idle <= '0;
            to_q <= 1'b0;
        end else begin
            idle <= (state == PAYLOAD && !pop) ? idle + 16'd1 : '0;
            to_q <= abort;
        end
    end
`else
    assign abort      = 1'b0;
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop && rdata != 8'h00) state_nx = (rdata[2:0] == 3'd0) ? HOLD : PAYLOAD;
            PAYLOAD: if (pop && idx == pkt_len - 3'd1) state_nx = HOLD;
                     else if (abort) state_nx = IDLE;
            HOLD:    if (pkt_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idx      <= '0;
            pkt_op   <= '0;
            pkt_len  <= '0;
            pkt_data <= '0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && pop && rdata != 8'h00) begin
                pkt_op   <= rdata[7:3];
                pkt_len  <= rdata[2:0];
                pkt_data <= '0;
                idx      <= '0;
            end
            if (state == PAYLOAD && pop) begin
                pkt_data[{idx, 3'b000} +: 8] <= rdata;
                idx                          <= idx + 3'd1;
            end
            if (abort) pkt_data <= '0;
            if (state == HOLD && pkt_ready) cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: doc/pkt_rx_framer.md
PKT_RX_FRAMER -- requirements
Module: pkt_rx_framer

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the idle cycles allowed mid-packet before abort; legal range 2..65535.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port rclk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port rrst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rdata, input, 8, FIFO head byte, valid whenever rempty=0 (show-ahead).
REQ-005 The block SHALL have port rempty, input, 1, FIFO empty flag.
REQ-006 The block SHALL have port rinc, output, 1, pop strobe to the FIFO.
REQ-007 The block SHALL have port pkt_valid, output, 1, assembled packet available.
REQ-008 The block SHALL have port pkt_ready, input, 1, consumer accepts the packet.
REQ-009 The block SHALL have port pkt_op, output, 5, opcode (header[7:3]).
REQ-010 The block SHALL have port pkt_len, output, 3, payload byte count (header[2:0]).
REQ-011 The block SHALL have port pkt_data, output, 56, payload bytes, little-endian.
REQ-012 The block SHALL have port pkt_count, output, 16, count of accepted packets.
REQ-013 The block SHALL have port rx_timeout, output, 1, one-cycle abort pulse.

Function
REQ-014 The FSM SHALL have states IDLE, PAYLOAD and HOLD.
REQ-015 rinc SHALL equal (!rempty && state is IDLE or PAYLOAD), combinationally, so each byte is consumed in the cycle it is popped.
REQ-016 In IDLE, a popped header 0x00 SHALL be discarded as padding, with the state staying IDLE.
REQ-017 In IDLE, a popped nonzero header SHALL latch op/len, clear pkt_data to zero and the byte index to 0, then go to HOLD if len=0, else PAYLOAD.
REQ-018 In PAYLOAD, each popped byte SHALL be written to pkt_data[8*i+7:8*i] at index i, and the index SHALL increment.
REQ-019 On popping byte index len-1, the FSM SHALL go to HOLD.
REQ-020 Unwritten pkt_data bytes SHALL read zero.
REQ-021 pkt_valid SHALL be 1 exactly in HOLD; pkt_op, pkt_len and pkt_data SHALL remain stable while pkt_valid=1.
REQ-022 In HOLD, rinc SHALL be 0; on pkt_ready=1 the FSM SHALL go to IDLE next cycle and pkt_count SHALL increment.
REQ-023 Header-pop to pkt_valid latency SHALL be 1 cycle for len=0, or len+1 cycles with back-to-back bytes.
REQ-024 Minimum spacing SHALL be 1 dead cycle (IDLE) between packets.
REQ-025 pkt_count SHALL wrap 0xFFFF to 0x0000.
REQ-026 pkt_ready while not in HOLD SHALL be ignored.
REQ-027 rempty=1 in IDLE or PAYLOAD SHALL stall with no state change, except as stated in REQ-031.

Reset
REQ-028 rrst_n low SHALL asynchronously force: state IDLE, pkt_valid 0, pkt_op 0, pkt_len 0, pkt_data 0, pkt_count 0, rx_timeout 0, byte index 0, timeout counter 0.
REQ-029 rinc SHALL be 0 during reset.
REQ-030 Reset asserted mid-packet or in HOLD SHALL discard the partial or held packet without incrementing pkt_count.

Configuration
REQ-031 With macro PKT_RX_TIMEOUT_EN defined, the block SHALL behave as follows.
- A 16-bit idle counter clears on every pop and on entering PAYLOAD, and increments each PAYLOAD cycle with rempty=1.
- When the counter equals TIMEOUT_CYCLES-1 with rempty=1, the FSM returns to IDLE next cycle, rx_timeout pulses 1 for that one cycle, the partial packet is dropped, pkt_count is unchanged, and pkt_data is cleared.
- A byte arriving in the same cycle as the terminal count is popped and counted normally; no abort occurs.
- The counter is inactive in IDLE and HOLD.
REQ-032 Without PKT_RX_TIMEOUT_EN, the counter logic SHALL be absent, rx_timeout SHALL be tied 0, and PAYLOAD SHALL wait indefinitely.

Verification
REQ-033 Feed header 0x0A then 0x11, 0x22 with pkt_ready=1 -> pkt_valid for 1 cycle 3 cycles after the header pop, pkt_op=0x01, pkt_len=2, pkt_data=0x...002211, pkt_count=1.
REQ-034 Feed 0x00, 0x00, 0xF8 with pkt_ready=0 for 5 cycles -> padding dropped, pkt_op=0x1F, pkt_len=0, pkt_valid held 5 cycles, rinc=0 throughout HOLD, then count +1 on ready.
REQ-035 Feed header 0x0F and 7 bytes 0x01..0x07 with gaps of 3 empty cycles -> pkt_data=0x07060504030201, correct stall behaviour with no rinc while rempty=1.
REQ-036 With PKT_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, feed 0x0B, 0xAA, then starve -> rx_timeout pulse after 16 empty cycles, no pkt_valid; subsequent 0x08 yields pkt_op=0x01, pkt_len=0, pkt_data=0.
REQ-037 Preload pkt_count=0xFFFF via 65535 len-0 packets, then accept one more -> pkt_count=0x0000.
REQ-038 Assert rrst_n low mid-PAYLOAD and during HOLD -> all outputs zero immediately, pkt_count unchanged from reset value 0, and the next clean packet parses correctly.
